conv_acc_buf: RTL and testbench

//  Partial-sum accumulation buffer serving conv_acc. It answers conv_acc's acc-channel

---
 rtl/conv_acc_buf_if.sv | 28 ++
 rtl/conv_acc_buf.sv | 128 ++++++++++++
 tb/tb_conv_acc_buf.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_acc_buf_if.sv
// Bus bundle between the layer controller / conv_acc side (master) and the
// partial-sum accumulation buffer (slave).
interface conv_acc_buf_if #(
  parameter int AW = 10,
  parameter int DW = 22,
  parameter int DN = 6
);
  logic                 start;
  logic [AW-1:0]        base;
  logic [9:0]           size;
  logic [AW-1:0]        rd_addr;
  logic [DW*DN-1:0]     rd_data;
  logic [DW*DN-1:0]     wr_data;
  logic                 wr_valid;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, base, size, rd_addr, wr_data, wr_valid,
    input  rd_data, busy, done, err
  );

  modport slave (
    input  start, base, size, rd_addr, wr_data, wr_valid,
    output rd_data, busy, done, err
  );
endinterface

// File: rtl/conv_acc_buf.sv
// Partial-sum buffer for conv_acc: 1-cycle write-first reads plus an
// address-less write stream placed by a burst descriptor with one pending slot.
//
//   state | meaning
//   IDLE  | no burst armed; writes are dropped and flagged
//   BURST | writes land at wr_ptr until remaining reaches zero
module conv_acc_buf #(
  parameter int AW = 10,
  parameter int DW = 22,
  parameter int DN = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  conv_acc_buf_if.slave bus
);
  localparam int W = DW * DN;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [10:0]     remaining_q, remaining_d;
  logic            pend_vld_q, pend_vld_d;
  logic [AW-1:0]   pend_base_q, pend_base_d;
  logic [9:0]      pend_size_q, pend_size_d;
  logic [W-1:0]    rd_data_q, rd_data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            wr_en;
  logic            final_wr;

  logic [W-1:0]    mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      pend_vld_q  <= 1'b0;
      pend_base_q <= '0;
      pend_size_q <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      pend_vld_q  <= pend_vld_d;
      pend_base_q <= pend_base_d;
      pend_size_q <= pend_size_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Storage is deliberately not reset so partial sums survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    pend_vld_d  = pend_vld_q;
    pend_base_d = pend_base_q;
    pend_size_d = pend_size_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    final_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wr_valid) err_d = 1'b1;
        if (bus.start) begin
          wr_ptr_d    = bus.base;
          remaining_d = {1'b0, bus.size} + 11'd1;
          state_d     = BURST;
        end
      end
      BURST: begin
        final_wr = bus.wr_valid && (remaining_q == 11'd1);
        if (bus.wr_valid) begin
          wr_ptr_d    = wr_ptr_q + 1'b1;
          remaining_d = remaining_q - 11'd1;
        end
        if (final_wr) begin
          if (pend_vld_q) begin
            // Pending slot frees up this cycle, so a coincident start can refill it.
            wr_ptr_d    = pend_base_q;
            remaining_d = {1'b0, pend_size_q} + 11'd1;
            pend_vld_d  = bus.start;
            if (bus.start) begin
              pend_base_d = bus.base;
              pend_size_d = bus.size;
            end
          end else if (bus.start) begin
            wr_ptr_d    = bus.base;
            remaining_d = {1'b0, bus.size} + 11'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (bus.start) begin
          if (pend_vld_q) begin
            err_d = 1'b1;
          end else begin
            pend_vld_d  = 1'b1;
            pend_base_d = bus.base;
            pend_size_d = bus.size;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en     = rst_n && (state_q == BURST) && bus.wr_valid;
    rd_data_d = (wr_en && (bus.rd_addr == wr_ptr_q)) ? bus.wr_data : mem_q[bus.rd_addr];
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = (state_q == BURST);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_conv_acc_buf.sv
// Bench for conv_acc_buf: directed scenarios plus random traffic, every cycle
// compared against a descriptor-queue model of the buffer.
module tb_conv_acc_buf;
  localparam int AW = 10;
  localparam int DW = 22;
  localparam int DN = 6;
  localparam int W  = DW * DN;
  localparam int DEPTH = 2 ** AW;

  typedef struct {
    int base;
    int size;
  } desc_t;

  logic clk;
  logic rst_n;

  conv_acc_buf_if #(.AW(AW), .DW(DW), .DN(DN)) bus ();

  conv_acc_buf #(.AW(AW), .DW(DW), .DN(DN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: descriptors in arrival order, head is the active burst.
  desc_t        dq[$];
  int           off;
  logic [W-1:0] mem_m [DEPTH];
  bit           known_m [DEPTH];
  logic [W-1:0] exp_rd;
  bit           exp_rd_known;
  logic         exp_busy, exp_done, exp_err;
  int           n_chk;
  int           n_fail;

  function automatic logic [W-1:0] rnd_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic model_step();
    bit  wrote;
    bit  fin;
    int  waddr;
    int  ra;
    if (!rst_n) begin
      exp_rd = '0; exp_rd_known = 1'b1;
      exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
      dq.delete(); off = 0;
      return;
    end
    wrote = 1'b0; fin = 1'b0; waddr = 0;
    exp_done = 1'b0; exp_err = 1'b0;
    ra = int'(bus.rd_addr);
    if (dq.size() == 0) begin
      if (bus.wr_valid) exp_err = 1'b1;
      if (bus.start) dq.push_back('{int'(bus.base), int'(bus.size)});
    end else begin
      if (bus.wr_valid) begin
        waddr = (dq[0].base + off) % DEPTH;
        wrote = 1'b1;
        off++;
        if (off == dq[0].size + 1) begin
          fin = 1'b1;
          void'(dq.pop_front());
          off = 0;
        end
      end
      if (bus.start) begin
        if (dq.size() < 2) dq.push_back('{int'(bus.base), int'(bus.size)});
        else exp_err = 1'b1;
      end
      if (fin && dq.size() == 0) exp_done = 1'b1;
    end
    if (wrote && ra == waddr) begin
      exp_rd = bus.wr_data; exp_rd_known = 1'b1;
    end else begin
      exp_rd = mem_m[ra]; exp_rd_known = known_m[ra];
    end
    if (wrote) begin
      mem_m[waddr] = bus.wr_data;
      known_m[waddr] = 1'b1;
    end
    exp_busy = (dq.size() > 0);
  endtask

  task automatic check();
    if (exp_rd_known) begin
      n_chk++;
      assert (bus.rd_data === exp_rd) else begin
        n_fail++;
        $error("FAIL rd_data got %h exp %h", bus.rd_data, exp_rd);
      end
    end
    n_chk++;
    assert (bus.busy === exp_busy) else begin
      n_fail++;
      $error("FAIL busy got %b exp %b", bus.busy, exp_busy);
    end
    n_chk++;
    assert (bus.done === exp_done) else begin
      n_fail++;
      $error("FAIL done got %b exp %b", bus.done, exp_done);
    end
    n_chk++;
    assert (bus.err === exp_err) else begin
      n_fail++;
      $error("FAIL err got %b exp %b", bus.err, exp_err);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check();
  endtask

  task automatic do_start(input int b, input int s);
    bus.start = 1'b1; bus.base = AW'(b); bus.size = 10'(s);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_write(input logic [W-1:0] d);
    bus.wr_valid = 1'b1; bus.wr_data = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_read(input int a);
    bus.rd_addr = AW'(a);
    tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; off = 0;
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base = '0; bus.size = '0;
    bus.rd_addr = '0; bus.wr_data = '0; bus.wr_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Fill every entry with a maximal burst so later reads are all defined.
    do_start(0, 1023);
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_addr = AW'($urandom());
      do_write(rnd_word());
    end
    tick();

    // Basic burst with a gap, then readback.
    do_start(5, 3);
    do_write(rnd_word());
    do_write(rnd_word());
    tick();
    do_write(rnd_word());
    do_write(rnd_word());
    tick();
    for (int a = 4; a <= 9; a++) do_read(a);
    do_read(7);

    // Address wrap at top of memory.
    do_start(1022, 3);
    for (int i = 0; i < 4; i++) do_write(rnd_word());
    tick();
    foreach (dq[i]) ; // model queue is empty here
    for (int a = 1021; a <= 1023; a++) do_read(a);
    for (int a = 0; a <= 2; a++) do_read(a);

    // Write-first collision.
    do_start(20, 1);
    bus.rd_addr = AW'(20);
    do_write(rnd_word());
    bus.rd_addr = AW'(21);
    do_write(rnd_word());
    tick();

    // Back-to-back descriptors, third start dropped.
    do_start(0, 1);
    do_start(100, 0);
    do_start(200, 2);
    for (int i = 0; i < 3; i++) do_write(rnd_word());
    tick();
    do_read(0); do_read(1); do_read(100); do_read(200);

    // Final write with pending full and a coincident start.
    do_start(400, 0);
    do_start(410, 1);
    bus.start = 1'b1; bus.base = AW'(420); bus.size = 10'd0;
    do_write(rnd_word());
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) do_write(rnd_word());
    tick();
    for (int a = 400; a <= 421; a++) do_read(a);

    // Final write with pending empty and a coincident start.
    do_start(500, 0);
    bus.start = 1'b1; bus.base = AW'(510); bus.size = 10'd1;
    do_write(rnd_word());
    bus.start = 1'b0;
    do_write(rnd_word());
    do_write(rnd_word());
    tick();

    // Stray write while idle.
    bus.rd_addr = AW'(700);
    do_write(rnd_word());
    do_read(0);
    do_read(700);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bus.start    = ($urandom_range(7) == 0);
      bus.base     = AW'($urandom());
      bus.size     = 10'($urandom_range(5));
      bus.wr_valid = ($urandom_range(9) < 6);
      bus.wr_data  = rnd_word();
      if (dq.size() > 0 && $urandom_range(1) == 1)
        bus.rd_addr = AW'((dq[0].base + off) % DEPTH);
      else
        bus.rd_addr = AW'($urandom());
      tick();
    end
    bus.start = 1'b0; bus.wr_valid = 1'b0;
    for (int i = 0; i < 30; i++) do_write(rnd_word());
    tick();

    // Reset mid-burst, then a fresh burst.
    do_start(300, 9);
    for (int i = 0; i < 3; i++) do_write(rnd_word());
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    do_start(310, 0);
    do_write(rnd_word());
    tick();
    for (int a = 299; a <= 311; a++) do_read(a);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
